// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Arbitrates fetch and MA-stage accesses onto one single-port
//            memory and produces the pipeline stall/flush enables.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [3:0]        ma_be,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic              ma_ack,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ena_fetch,
    output logic              ena_ifid,
    output logic              ena_idex,
    output logic              ena_exma,
    output logic              ena_mawb,
    output logic              flush_ifid,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_BUSY_IF = 3'd1;
    localparam logic [2:0] c_BUSY_MA = 3'd2;
    localparam logic [2:0] c_DONE    = 3'd3;
    localparam logic [2:0] c_ERR     = 3'd4;

    localparam logic c_GNT_IF = 1'b0;
    localparam logic c_GNT_MA = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             w_grant_if;
    logic             w_grant_ma;
    logic             w_busy;

    assign w_busy = (r_state == c_BUSY_IF) || (r_state == c_BUSY_MA);

    // On a tie the requester that did not win the previous grant goes first.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_ma  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (ma_req && (!if_req || (r_last_grant == c_GNT_IF))) begin
                    w_state_nxt = c_BUSY_MA;
                    w_grant_ma  = 1'b1;
                end else if (if_req) begin
                    w_state_nxt = c_BUSY_IF;
                    w_grant_if  = 1'b1;
                end
            end
            c_BUSY_IF, c_BUSY_MA: begin
                if (mem_ack) begin
                    w_state_nxt = c_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ERR;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            c_ERR:   w_state_nxt = c_ERR;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_last_grant <= c_GNT_IF;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 4'b0000;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_ack       <= 1'b0;
            ma_ack       <= 1'b0;
            if_rdata     <= '0;
            ma_rdata     <= '0;
            err          <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if_ack  <= 1'b0;
            ma_ack  <= 1'b0;
            if (w_grant_ma) begin
                mem_req      <= 1'b1;
                mem_we       <= ma_we;
                mem_be       <= ma_be;
                mem_addr     <= ma_addr;
                mem_wdata    <= ma_wdata;
                r_cnt        <= '0;
                r_last_grant <= c_GNT_MA;
            end else if (w_grant_if) begin
                mem_req      <= 1'b1;
                mem_we       <= 1'b0;
                mem_be       <= 4'b1111;
                mem_addr     <= if_addr;
                mem_wdata    <= '0;
                r_cnt        <= '0;
                r_last_grant <= c_GNT_IF;
            end else if (w_busy) begin
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (r_state == c_BUSY_IF) begin
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                    end else begin
                        ma_ack   <= 1'b1;
                        ma_rdata <= mem_rdata;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_state_nxt == c_ERR) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end
                end
            end
        end
    end

    // A pending data access stalls the whole pipe; a pending fetch only
    // bubbles IF/ID so the younger stages keep draining.
    always_comb begin
        ena_fetch  = 1'b1;
        ena_ifid   = 1'b1;
        ena_idex   = 1'b1;
        ena_exma   = 1'b1;
        ena_mawb   = 1'b1;
        flush_ifid = 1'b0;
        if ((r_state == c_ERR) || (ma_req && !ma_ack)) begin
            ena_fetch = 1'b0;
            ena_ifid  = 1'b0;
            ena_idex  = 1'b0;
            ena_exma  = 1'b0;
            ena_mawb  = 1'b0;
        end else if (if_req && !if_ack) begin
            ena_fetch  = 1'b0;
            flush_ifid = 1'b1;
        end
    end

endmodule
`default_nettype wire
